rr_resource_arbiter: RTL and testbench

Round-robin arbiter that shares one resource, such as a memory port or bus slave, among N requesters with a request/grant/done handshake. It generalises the team's two-requester grant FSM to N requesters with fair rotation, a bounded hold time and an explicit release cycle for bus turnaround. It sits between the requesting masters and the shared resource's select/mux logic. The encoded owner drives the resource's input mux.

---
 rtl/rr_arb_pkg.sv | 10 +
 rtl/rr_pick.sv | 23 ++
 rtl/rr_resource_arbiter.sv | 81 ++++++++
 tb/tb_rr_resource_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state encoding and index helpers for the round-robin arbiter.
package rr_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  function automatic int inc_mod(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr, wrapping at N.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [N-1:0] hi;
  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) hi[i] = req[i] && (i >= int'(ptr));
    idx = '0;
    // lowest request overall is the wraparound fallback; a hit at/above ptr overrides it
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
    for (int i = N - 1; i >= 0; i--) if (hi[i]) idx = IW'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: N-way round-robin grant FSM with hold limit and a one-cycle
// release slot between owners for bus turnaround.
module rr_resource_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  localparam int IW      = idx_w(N),
  localparam int CW      = idx_w(MAX_HOLD)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] owner,
  output logic          busy,
  output logic          timeout
);
  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n, owner_n, win;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  grant_n;
  logic          timeout_n, win_ok, hold_done, hold_drop, at_limit, leave;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (win),
    .valid (win_ok)
  );

  assign hold_done = done[owner];
  assign hold_drop = !req[owner];
  assign at_limit  = cnt == CW'(MAX_HOLD - 1);
  assign leave     = hold_done | hold_drop | at_limit;
  assign busy      = |grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      owner   <= owner_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      timeout <= timeout_n;
    end
  end

  always_comb begin
    state_n = (state == IDLE)  ? (win_ok ? GRANT : IDLE) :
              (state == GRANT) ? (leave ? RELEASE : GRANT) : IDLE;
  end

  always_comb begin
    grant_n   = grant;
    owner_n   = owner;
    ptr_n     = ptr;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    if (state == IDLE && win_ok) begin
      grant_n = N'(1) << win;
      owner_n = win;
      cnt_n   = '0;
    end
    // timeout only flags a revocation the owner did not ask for itself
    if (state == GRANT) begin
      grant_n   = leave ? '0 : grant;
      cnt_n     = leave ? cnt : cnt + CW'(1);
      timeout_n = at_limit & !hold_done & !hold_drop;
    end
    if (state == RELEASE) ptr_n = IW'(inc_mod(int'(owner), N));
  end
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb_rr_resource_arbiter: directed vector table, N=3 wrap sequence and a
// model-scored random soak for the round-robin arbiter.
module tb_rr_resource_arbiter;
  localparam int N = 4, MH = 4, BOUND = N * (MH + 2);
  logic       clock = 1'b0, reset = 1'b0;
  logic [3:0] req = '0, done = '0, grant;
  logic [1:0] owner;
  logic       busy, timeout;
  logic [2:0] req3 = '0, done3 = '0, grant3;
  logic [1:0] owner3;
  logic       busy3, timeout3;
  int checks = 0, errors = 0;

  typedef struct { logic rst; logic [3:0] rq, dn, g; logic [1:0] o; logic t; string name; } vec_t;
  typedef struct { logic [3:0] g; logic [1:0] o; logic t; string name; } exp_t;
  vec_t tbl[$];
  exp_t exp_q[$];

  int m_state, m_owner, m_ptr, m_cnt;
  logic [3:0] m_grant;
  logic m_to;
  int wait_c[N];
  int max_w = 0;

  always #5 clock = ~clock;

  rr_resource_arbiter #(.N(4), .MAX_HOLD(MH)) u4 (
    .clock(clock), .reset(reset), .req(req), .done(done),
    .grant(grant), .owner(owner), .busy(busy), .timeout(timeout)
  );

  rr_resource_arbiter #(.N(3), .MAX_HOLD(MH)) u3 (
    .clock(clock), .reset(reset), .req(req3), .done(done3),
    .grant(grant3), .owner(owner3), .busy(busy3), .timeout(timeout3)
  );

  task automatic check(string name, logic [7:0] act, logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h ({grant,owner,busy,timeout})", name, act, want);
    end
  endtask

  function automatic void add(logic rst, logic [3:0] rq, dn, g, logic [1:0] o, logic t, string name);
    vec_t v;
    v.rst = rst; v.rq = rq; v.dn = dn; v.g = g; v.o = o; v.t = t; v.name = name;
    tbl.push_back(v);
  endfunction

  function automatic void fill();
    logic [3:0] oh;
    for (int k = 0; k < 5; k++) begin
      oh = 4'(1 << (k % 4));
      add(k == 0, 4'hF, 4'h0, oh, 2'(k % 4), 1'b0, "rot_grant");
      add(1'b0, 4'hF, 4'h0, oh, 2'(k % 4), 1'b0, "rot_hold");
      add(1'b0, 4'hF, oh, 4'h0, 2'(k % 4), 1'b0, "rot_done");
      add(1'b0, 4'hF, 4'h0, 4'h0, 2'(k % 4), 1'b0, "rot_gap");
    end
    add(1'b0, 4'h2, 4'h0, 4'h2, 2'd1, 1'b0, "to_grant");
    for (int k = 0; k < 3; k++) add(1'b0, 4'h2, 4'h0, 4'h2, 2'd1, 1'b0, "to_hold");
    add(1'b0, 4'h2, 4'h0, 4'h0, 2'd1, 1'b1, "to_pulse");
    add(1'b0, 4'h2, 4'h0, 4'h0, 2'd1, 1'b0, "to_gap");
    add(1'b0, 4'h2, 4'h0, 4'h2, 2'd1, 1'b0, "to_regrant");
    for (int k = 0; k < 3; k++) add(1'b0, 4'h2, 4'h0, 4'h2, 2'd1, 1'b0, "sim_hold");
    add(1'b0, 4'h0, 4'h2, 4'h0, 2'd1, 1'b0, "sim_exit");
    add(1'b0, 4'h0, 4'h0, 4'h0, 2'd1, 1'b0, "sim_gap");
    add(1'b0, 4'h1, 4'h0, 4'h1, 2'd0, 1'b0, "nonowner_grant");
    add(1'b0, 4'h1, 4'hE, 4'h1, 2'd0, 1'b0, "nonowner_done");
    add(1'b0, 4'h1, 4'h0, 4'h1, 2'd0, 1'b0, "nonowner_hold");
    add(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, "withdraw");
    add(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, "wd_gap");
  endfunction

  function automatic void model_reset();
    m_state = 0; m_grant = '0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
  endfunction

  function automatic void model_step(logic [3:0] rq, logic [3:0] dn);
    int j;
    logic lim, ex;
    j = 0;
    m_to = 1'b0;
    if (m_state == 0) begin
      if (rq != 4'h0) begin
        for (int k = N - 1; k >= 0; k--) if (rq[(m_ptr + k) % N]) j = (m_ptr + k) % N;
        m_grant = 4'(1 << j); m_owner = j; m_cnt = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      lim = (m_cnt == MH - 1);
      ex = dn[m_owner] || !rq[m_owner] || lim;
      if (ex) begin
        m_to = lim && !dn[m_owner] && rq[m_owner];
        m_grant = '0; m_state = 2;
      end else m_cnt++;
    end else begin
      m_ptr = (m_owner + 1) % N; m_state = 0;
    end
  endfunction

  task automatic drive(logic [3:0] rq, dn, g, logic [1:0] o, logic t, string name);
    exp_t e, x;
    @(negedge clock);
    req = rq; done = dn;
    e.g = g; e.o = o; e.t = t; e.name = name;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    x = exp_q.pop_front();
    check(x.name, {grant, owner, busy, timeout}, {x.g, x.o, |x.g, x.t});
  endtask

  task automatic step3(logic [2:0] rq, dn, g, logic [1:0] o, logic t, string name);
    @(negedge clock);
    req3 = rq; done3 = dn;
    @(posedge clock);
    #1;
    check(name, {1'b0, grant3, owner3, busy3, timeout3}, {1'b0, g, o, |g, t});
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1; req = '0; done = '0; req3 = '0; done3 = '0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] rq, dn;
    fill();
    #1 reset = 1'b1;
    #2 check("reset_state", {grant, owner, busy, timeout}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    drive(4'h4, 4'h0, 4'h4, 2'd2, 1'b0, "pre_grant");
    drive(4'h4, 4'h0, 4'h4, 2'd2, 1'b0, "pre_hold");
    #2 reset = 1'b1;
    #1 check("mid_reset", {grant, owner, busy, timeout}, 8'h00);
    reset = 1'b0;
    drive(4'h4, 4'h0, 4'h4, 2'd2, 1'b0, "post_reset_grant");
    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset();
      drive(tbl[i].rq, tbl[i].dn, tbl[i].g, tbl[i].o, tbl[i].t, tbl[i].name);
    end
    pulse_reset();
    step3(3'b100, 3'b000, 3'b100, 2'd2, 1'b0, "w_grant");
    step3(3'b000, 3'b000, 3'b000, 2'd2, 1'b0, "w_withdraw");
    step3(3'b011, 3'b000, 3'b000, 2'd2, 1'b0, "w_release");
    step3(3'b011, 3'b000, 3'b001, 2'd0, 1'b0, "w_wrap");
    step3(3'b011, 3'b001, 3'b000, 2'd0, 1'b0, "w_done");
    step3(3'b011, 3'b000, 3'b000, 2'd0, 1'b0, "w_gap");
    step3(3'b011, 3'b000, 3'b010, 2'd1, 1'b0, "w_next");
    pulse_reset();
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) rq[i] = ($urandom_range(0, 2) == 0);
        else if (m_grant[i]) rq[i] = ($urandom_range(0, 3) != 0);
        else rq[i] = 1'b1;
      end
      dn = (($urandom_range(0, 3) == 0) ? m_grant : 4'h0) |
           (($urandom_range(0, 4) == 0) ? (4'($urandom_range(0, 15)) & ~m_grant) : 4'h0);
      model_step(rq, dn);
      drive(rq, dn, m_grant, 2'(m_owner), m_to, "soak");
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL soak_onehot: grant %b is not one-hot or zero", grant);
      end
      for (int i = 0; i < N; i++) begin
        wait_c[i] = (req[i] && !grant[i]) ? wait_c[i] + 1 : 0;
        if (wait_c[i] > max_w) max_w = wait_c[i];
      end
    end
    checks++;
    if (max_w > BOUND) begin
      errors++;
      $display("FAIL max_wait: got %0d cycles, limit %0d", max_w, BOUND);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
